// File: rtl/round_ctrl.sv
// Whack-a-mole round sequencer: countdown per round, hit counting, round advance, win/lose.
// Optional ROUND_SHRINK_EN: later rounds load a shorter countdown (ROUND_SECS - 5*round, floored).
module round_ctrl #(
  parameter int TICK_DIV    = 25000000,
  parameter int ROUND_SECS  = 30,
  parameter int HITS_TO_ADV = 10,
  parameter int GAP_SECS    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  output logic [1:0] round,
  output logic [5:0] time_left,
  output logic [3:0] hit_cnt,
  output logic       playing,
  output logic       game_over,
  output logic       win
);
  localparam int         TW = $clog2(TICK_DIV);
  localparam logic [5:0] RS = 6'(ROUND_SECS);
  localparam logic [3:0] HA = 4'(HITS_TO_ADV);
  localparam logic [3:0] GL = 4'(GAP_SECS - 1);

  typedef enum logic [2:0] {IDLE, PLAY, GAP, WIN, LOSE} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [3:0]    gcnt;
  logic          tick;
  logic [3:0]    hit_nx;
  logic          clear;
  logic [5:0]    next_load;

  assign tick   = (tcnt == TW'(TICK_DIV - 1));
  assign hit_nx = hit_cnt + 4'd1;
  assign clear  = hit && (hit_nx == HA);

`ifdef ROUND_SHRINK_EN
  function automatic logic [5:0] load_time(input logic [1:0] r);
    int t, fl;
    t  = ROUND_SECS - 5 * int'(r);
    fl = (ROUND_SECS < 5) ? ROUND_SECS : 5;
    if (t < fl) t = fl;
    return 6'(t);
  endfunction
  assign next_load = load_time(round + 2'd1);
`else
  assign next_load = RS;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round     <= '0;
      time_left <= RS;
      hit_cnt   <= '0;
      tcnt      <= '0;
      gcnt      <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, LOSE: begin
          if (start) begin
            state     <= PLAY;
            round     <= '0;
            hit_cnt   <= '0;
            time_left <= RS;
            tcnt      <= '0;
            playing   <= 1'b1;
            game_over <= 1'b0;
            win       <= 1'b0;
          end
        end
        PLAY: begin
          tcnt <= tick ? '0 : tcnt + TW'(1);
          if (hit) hit_cnt <= hit_nx;
          // A clearing hit beats a same-cycle timeout and freezes time_left.
          if (clear) begin
            tcnt    <= '0;
            gcnt    <= '0;
            playing <= 1'b0;
            if (round == 2'd3) begin
              state <= WIN;
              win   <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else if (tick) begin
            time_left <= time_left - 6'd1;
            if (time_left == 6'd1) begin
              state     <= LOSE;
              playing   <= 1'b0;
              game_over <= 1'b1;
              tcnt      <= '0;
            end
          end
        end
        GAP: begin
          tcnt <= tick ? '0 : tcnt + TW'(1);
          if (tick) begin
            if (gcnt == GL) begin
              state     <= PLAY;
              round     <= round + 2'd1;
              hit_cnt   <= '0;
              time_left <= next_load;
              playing   <= 1'b1;
            end else begin
              gcnt <= gcnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: expectations queued with stimulus, popped at sample points.
module tb_round_ctrl;
  typedef struct packed {
    logic [1:0] rnd;
    logic [5:0] tl;
    logic [3:0] hc;
    logic       p;
    logic       go;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 0, hit_a = 0, start_b = 0, hit_b = 0, start_c = 0, hit_c = 0;
  logic [1:0] round_a, round_b, round_c;
  logic [5:0] tl_a, tl_b, tl_c;
  logic [3:0] hc_a, hc_b, hc_c;
  logic p_a, p_b, p_c, go_a, go_b, go_c, w_a, w_b, w_c;
  exp_t obs_a, obs_b, obs_c, e;
  exp_t sb[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign obs_a = {round_a, tl_a, hc_a, p_a, go_a, w_a};
  assign obs_b = {round_b, tl_b, hc_b, p_b, go_b, w_b};
  assign obs_c = {round_c, tl_c, hc_c, p_c, go_c, w_c};

  round_ctrl #(.TICK_DIV(4), .ROUND_SECS(3), .HITS_TO_ADV(2), .GAP_SECS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .hit(hit_a), .round(round_a), .time_left(tl_a),
    .hit_cnt(hc_a), .playing(p_a), .game_over(go_a), .win(w_a));
  round_ctrl #(.TICK_DIV(4), .ROUND_SECS(3), .HITS_TO_ADV(3), .GAP_SECS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .hit(hit_b), .round(round_b), .time_left(tl_b),
    .hit_cnt(hc_b), .playing(p_b), .game_over(go_b), .win(w_b));
  round_ctrl #(.TICK_DIV(4), .ROUND_SECS(12), .HITS_TO_ADV(2), .GAP_SECS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .hit(hit_c), .round(round_c), .time_left(tl_c),
    .hit_cnt(hc_c), .playing(p_c), .game_over(go_c), .win(w_c));

  function automatic exp_t mk(int r, int t, int h, bit p, bit go, bit w);
    mk = {2'(r), 6'(t), 4'(h), p, go, w};
  endfunction

  // Loaded countdown for dut_c (ROUND_SECS=12) in a given round.
  function automatic int load_c(int r);
`ifdef ROUND_SHRINK_EN
    load_c = (12 - 5 * r < 5) ? 5 : 12 - 5 * r;
`else
    load_c = (r >= 0) ? 12 : 12;
`endif
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int which);
    if (which == 0) start_a = 1; else if (which == 1) start_b = 1; else start_c = 1;
    step(1);
    start_a = 0; start_b = 0; start_c = 0;
  endtask

  task automatic pulse_hit(int which);
    if (which == 0) hit_a = 1; else if (which == 1) hit_b = 1; else hit_c = 1;
    step(1);
    hit_a = 0; hit_b = 0; hit_c = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(2);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    sb.push_back(mk(0, 3, 0, 0, 0, 0));
    step(2);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL reset got=%h want=%h", obs_a, e); end
    rst_n = 1;
  endtask

  task automatic test_timeout();
    sb.push_back(mk(0, 3, 0, 1, 0, 0));
    sb.push_back(mk(0, 2, 0, 1, 0, 0));
    sb.push_back(mk(0, 1, 0, 1, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 1, 0));
    pulse_start(0);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL timeout_start got=%h want=%h", obs_a, e); end
    for (int i = 0; i < 3; i++) begin
      step(4);
      e = sb.pop_front(); total++;
      if (obs_a !== e) begin bad++; $display("FAIL timeout_tick%0d got=%h want=%h", i, obs_a, e); end
    end
  endtask

  task automatic test_gap();
    sb.push_back(mk(0, 3, 2, 0, 0, 0));
    sb.push_back(mk(1, 3, 0, 1, 0, 0));
    pulse_start(0);
    pulse_hit(0);
    pulse_hit(0);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL gap_enter got=%h want=%h", obs_a, e); end
    step(4);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL gap_exit got=%h want=%h", obs_a, e); end
  endtask

  // Continues from round 1 PLAY left by test_gap.
  task automatic test_win();
    sb.push_back(mk(3, 3, 2, 0, 0, 1));
    sb.push_back(mk(3, 3, 2, 0, 0, 1));
    sb.push_back(mk(0, 3, 0, 1, 0, 0));
    for (int r = 1; r < 3; r++) begin
      pulse_hit(0); pulse_hit(0); step(4);
    end
    pulse_hit(0); pulse_hit(0);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL win_enter got=%h want=%h", obs_a, e); end
    pulse_hit(0); pulse_hit(0); step(5);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL win_hold got=%h want=%h", obs_a, e); end
    pulse_start(0);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL win_restart got=%h want=%h", obs_a, e); end
  endtask

  // Hit coinciding with the final tick: clearing hit -> GAP, non-clearing -> LOSE.
  task automatic test_hit_tick_tie();
    sb.push_back(mk(0, 1, 1, 1, 0, 0));
    sb.push_back(mk(0, 1, 2, 0, 0, 0));
    pulse_hit(0);
    step(10);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL tie_pre got=%h want=%h", obs_a, e); end
    pulse_hit(0);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL tie_clear got=%h want=%h", obs_a, e); end
    sb.push_back(mk(0, 0, 2, 0, 1, 0));
    pulse_start(1);
    pulse_hit(1);
    step(10);
    pulse_hit(1);
    e = sb.pop_front(); total++;
    if (obs_b !== e) begin bad++; $display("FAIL tie_noclear got=%h want=%h", obs_b, e); end
  endtask

  task automatic test_async_reset();
    do_reset();
    sb.push_back(mk(2, 3, 2, 0, 0, 0));
    sb.push_back(mk(0, 3, 0, 0, 0, 0));
    sb.push_back(mk(0, 3, 0, 0, 0, 0));
    pulse_start(0);
    for (int r = 0; r < 2; r++) begin
      pulse_hit(0); pulse_hit(0); step(4);
    end
    pulse_hit(0); pulse_hit(0);
    step(1);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL gap_r2 got=%h want=%h", obs_a, e); end
    #2 rst_n = 0;
    #1;
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL async_reset got=%h want=%h", obs_a, e); end
    step(1);
    rst_n = 1;
    pulse_hit(0); pulse_hit(0); step(2);
    e = sb.pop_front(); total++;
    if (obs_a !== e) begin bad++; $display("FAIL idle_hits got=%h want=%h", obs_a, e); end
  endtask

  task automatic test_shrink();
    for (int r = 0; r < 4; r++) sb.push_back(mk(r, load_c(r), 0, 1, 0, 0));
    pulse_start(2);
    e = sb.pop_front(); total++;
    if (obs_c !== e) begin bad++; $display("FAIL shrink_r0 got=%h want=%h", obs_c, e); end
    for (int r = 1; r < 4; r++) begin
      pulse_hit(2); pulse_hit(2); step(4);
      e = sb.pop_front(); total++;
      if (obs_c !== e) begin bad++; $display("FAIL shrink_r%0d got=%h want=%h", r, obs_c, e); end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_gap();
    test_win();
    test_hit_tick_tie();
    test_async_reset();
    test_shrink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
